swap_frame_buffer: RTL and testbench
====================================

SWAP_FRAME_BUFFER -- requirements
Module: swap_frame_buffer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16, stored pixel width in RGB565 format.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 320, stored frame width in pixels.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 180, stored frame height in pixels.
REQ-004 SHALL have parameter SCALE_SHIFT, default 2, display upscale factor of 2^SCALE_SHIFT per axis.
REQ-005 SHALL have parameter ACTIVE_WIDTH, default 1280, active display width.
REQ-006 SHALL have parameter ACTIVE_HEIGHT, default 720, active display height.
REQ-007 SHALL have port pixel_clk_in, input, width 1, the only clock.
REQ-008 SHALL have port rst_n_in, input, width 1, asynchronous active-low reset.
REQ-009 SHALL have port hcount_in, input, width 11, display x position.
REQ-010 SHALL have port vcount_in, input, width 10, display y position.
REQ-011 SHALL have port video_last_pixel_in, input, width 1, single-cycle pulse marking the end of the displayed frame.
REQ-012 SHALL have port wr_valid_in, input, width 1, write request.
REQ-013 SHALL have port wr_addr_in, input, width clog2(SCREEN_WIDTH*SCREEN_HEIGHT), flat write address; arrival order arbitrary.
REQ-014 SHALL have port wr_pixel_in, input, width PIXEL_WIDTH, write data.
REQ-015 SHALL have port wr_last_in, input, width 1, marks the final write of a rendered frame.
REQ-016 SHALL have port wr_ready_out, output, width 1, write side may accept a write.
REQ-017 SHALL have port rgb_out, output, width 24, expanded RGB888 pixel.
REQ-018 SHALL have port rgb_valid_out, output, width 1, rgb_out belongs to an active-area pixel.
REQ-019 SHALL have port swap_out, output, width 1, one-cycle pulse on each buffer swap.
REQ-020 SHALL have port frame_count_out, output, width 16, number of swaps since reset, wrapping.

Function
REQ-021 SHALL hold two buffers of SCREEN_WIDTH*SCREEN_HEIGHT entries; state bit sel=0 means writes go to buffer A and reads come from buffer B, and sel=1 means the reverse.
REQ-022 SHALL accept a write when wr_valid_in && wr_ready_out, and SHALL drop writes with wr_addr_in >= SCREEN_WIDTH*SCREEN_HEIGHT without altering memory, while still honouring wr_last_in.
REQ-023 SHALL form the read address as (hcount_in>>SCALE_SHIFT) + SCREEN_WIDTH*(vcount_in>>SCALE_SHIFT), and SHALL use address 0 outside the active area.
REQ-024 SHALL give a read latency of exactly 2 cycles: rgb_out and rgb_valid_out correspond to the hcount_in/vcount_in sampled 2 cycles earlier.
REQ-025 SHALL set rgb_valid_out = (hcount < ACTIVE_WIDTH && vcount < ACTIVE_HEIGHT), delayed 2 cycles; rgb_out SHALL be 0 when invalid.
REQ-026 SHALL expand RGB565 to RGB888 as {R,R[4:2]},{G,G[5:4]},{B,B[4:2]}, so full scale maps to 0xFF.
REQ-027 SHALL implement the swap controller as an FSM with three states: RUN, WR_DONE (ray frame complete), and VID_DONE (display frame complete).
REQ-028 In RUN, an accepted wr_last_in SHALL go to WR_DONE; video_last_pixel_in SHALL go to VID_DONE; both in the same cycle SHALL swap and stay in RUN.
REQ-029 In WR_DONE, video_last_pixel_in SHALL swap and go to RUN; in VID_DONE, an accepted wr_last_in SHALL swap and go to RUN.
REQ-030 A swap SHALL toggle sel on the next edge, pulse swap_out for 1 cycle, and increment frame_count_out.
REQ-031 wr_ready_out SHALL be 0 in WR_DONE and 1 otherwise; writes are therefore never lost across a swap.
REQ-032 A repeated video_last_pixel_in while in VID_DONE SHALL be ignored, with no double count.

Reset
REQ-033 While rst_n_in=0 (asynchronous): sel=0, state RUN, swap_out=0, frame_count_out=0, rgb_out=0, rgb_valid_out=0, read pipeline cleared, wr_ready_out=1.
REQ-034 Buffer contents SHALL be retained across reset; reset mid-frame SHALL discard the pending done flags.

Configuration
REQ-035 With macro FB_TEST_PATTERN_EN defined, rgb_out SHALL show an 8-bar colour pattern indexed by hcount[10:8] until the first swap after reset; without the macro, buffer B contents SHALL be shown from reset.

Structure
REQ-036 Package fb_pkg SHALL hold the rgb565_t typedef, the swap FSM state enum, and the RGB565-to-888 expansion function.
REQ-037 The FSM and frame counter SHALL be in sub-module fb_swap_ctrl; the two buffers SHALL be xilinx_single_port_ram_read_first instances in HIGH_PERFORMANCE mode.

Verification
REQ-038 Write 0xF800 to addr 0 with wr_last, then pulse video_last: one swap_out pulse, frame_count_out=1, and rgb_out=0xFF0000 at h=0..3, v=0..3, two cycles after addressing.
REQ-039 wr_last, then 100 further wr_valid cycles before video_last: wr_ready_out=0 throughout, and the old write buffer is unmodified.
REQ-040 wr_last and video_last in the same cycle: exactly one swap, FSM returns to RUN, sel toggles.
REQ-041 Write to addr 57600 (out of range): memory unchanged; with wr_last set, the FSM still enters WR_DONE.
REQ-042 rst_n_in deasserted while in WR_DONE: immediately wr_ready_out=1, frame_count_out=0, and a previously written pixel is still readable after the next swap.
REQ-043 hcount=1280, vcount=0: rgb_valid_out=0 and rgb_out=0 two cycles later.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : fb_pkg                                                |
// | Purpose   : Shared types and helpers for the swap frame buffer:   |
// |             RGB565 pixel type, swap FSM state encoding, colour    |
// |             expansion and the optional test-pattern palette.      |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package fb_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WR_DONE  = 2'd1,
    ST_VID_DONE = 2'd2
  } swap_state_t;

  // Replicate the top bits into the new LSBs so full scale reaches 0xFF.
  function automatic logic [23:0] rgb565_to_888(input rgb565_t p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Classic 8-bar colour pattern, brightest bar first.
  function automatic logic [23:0] test_bar(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : fb_swap_ctrl                                          |
// | Purpose   : Decides when the render and display buffers swap.     |
// |             A swap needs both the render side (accepted wr_last)  |
// |             and the display side (video_last) to have finished.   |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        wr_last_acc_in,
  input  logic        video_last_in,
  output logic        sel_out,
  output logic        wr_ready_out,
  output logic        swap_out,
  output logic [15:0] frame_count_out
);

  swap_state_t r_state;
  logic        r_sel;
  logic        r_wr_ready;
  logic        r_swap;
  logic [15:0] r_count;

  // Swap FSM; all outputs registered. Ready drops only while waiting in WR_DONE.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_RUN;
      r_sel      <= 1'b0;
      r_wr_ready <= 1'b1;
      r_swap     <= 1'b0;
      r_count    <= 16'd0;
    end else begin
      r_swap <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (wr_last_acc_in && video_last_in) begin
            r_sel   <= ~r_sel;
            r_swap  <= 1'b1;
            r_count <= r_count + 16'd1;
          end else if (wr_last_acc_in) begin
            r_state    <= ST_WR_DONE;
            r_wr_ready <= 1'b0;
          end else if (video_last_in) begin
            r_state <= ST_VID_DONE;
          end
        end
        ST_WR_DONE: begin
          if (video_last_in) begin
            r_state    <= ST_RUN;
            r_wr_ready <= 1'b1;
            r_sel      <= ~r_sel;
            r_swap     <= 1'b1;
            r_count    <= r_count + 16'd1;
          end
        end
        ST_VID_DONE: begin
          // Further video_last pulses here are ignored.
          if (wr_last_acc_in) begin
            r_state <= ST_RUN;
            r_sel   <= ~r_sel;
            r_swap  <= 1'b1;
            r_count <= r_count + 16'd1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign sel_out         = r_sel;
  assign wr_ready_out    = r_wr_ready;
  assign swap_out        = r_swap;
  assign frame_count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/xilinx_single_port_ram_read_first.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : xilinx_single_port_ram_read_first                     |
// | Purpose   : Single-port block RAM, read-first behaviour, with an  |
// |             optional output register (HIGH_PERFORMANCE mode gives |
// |             two cycles of read latency, LOW_LATENCY gives one).   |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 16,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_ram_data;

  // Read-first array: the old word is returned on the cycle it is overwritten.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) r_mem[addra] <= dina;
      r_ram_data <= r_mem[addra];
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
      assign douta = r_ram_data;
    end else begin : g_high_performance
      logic [RAM_WIDTH-1:0] r_douta;
      // Output register adds the second cycle of read latency.
      always_ff @(posedge clka) begin
        if (rsta)        r_douta <= '0;
        else if (regcea) r_douta <= r_ram_data;
      end
      assign douta = r_douta;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/swap_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : swap_frame_buffer                                     |
// | Purpose   : Double-buffered frame store. One buffer takes render  |
// |             writes while the other is scanned out (upscaled by    |
// |             2^SCALE_SHIFT) as RGB888 with 2-cycle read latency.   |
// | Options   : FB_TEST_PATTERN_EN - show colour bars until the first |
// |             swap after reset.                                     |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module swap_frame_buffer
  import fb_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 16,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SCALE_SHIFT   = 2,
  parameter int ACTIVE_WIDTH  = 1280,
  parameter int ACTIVE_HEIGHT = 720
) (
  input  logic                                            pixel_clk_in,
  input  logic                                            rst_n_in,
  input  logic [10:0]                                     hcount_in,
  input  logic [9:0]                                      vcount_in,
  input  logic                                            video_last_pixel_in,
  input  logic                                            wr_valid_in,
  input  logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0]   wr_addr_in,
  input  logic [PIXEL_WIDTH-1:0]                          wr_pixel_in,
  input  logic                                            wr_last_in,
  output logic                                            wr_ready_out,
  output logic [23:0]                                     rgb_out,
  output logic                                            rgb_valid_out,
  output logic                                            swap_out,
  output logic [15:0]                                     frame_count_out
);

  localparam int              c_depth    = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int              c_addr_w   = $clog2(c_depth);
  localparam logic [10:0]     c_active_w = 11'(ACTIVE_WIDTH);
  localparam logic [9:0]      c_active_h = 10'(ACTIVE_HEIGHT);
  localparam logic [c_addr_w:0] c_depth_v = (c_addr_w+1)'(c_depth);

  logic                   w_sel;
  logic                   w_wr_accept;
  logic                   w_wr_mem;
  logic                   w_wr_last_acc;
  logic                   w_in_active;
  logic [c_addr_w-1:0]    w_rd_addr;
  logic [c_addr_w-1:0]    w_addr_a;
  logic [c_addr_w-1:0]    w_addr_b;
  logic [PIXEL_WIDTH-1:0] w_dout_a;
  logic [PIXEL_WIDTH-1:0] w_dout_b;
  logic [PIXEL_WIDTH-1:0] w_rd_pix;
  logic                   r_valid_d1;
  logic                   r_valid_d2;
  logic                   r_sel_d1;
  logic                   r_sel_d2;

  // Out-of-range writes are accepted (so wr_last still counts) but never stored.
  assign w_wr_accept   = wr_valid_in && wr_ready_out;
  assign w_wr_mem      = w_wr_accept && ({1'b0, wr_addr_in} < c_depth_v);
  assign w_wr_last_acc = w_wr_accept && wr_last_in;

  assign w_in_active = (hcount_in < c_active_w) && (vcount_in < c_active_h);
  assign w_rd_addr   = w_in_active
                     ? (c_addr_w'(hcount_in >> SCALE_SHIFT)
                        + c_addr_w'(SCREEN_WIDTH) * c_addr_w'(vcount_in >> SCALE_SHIFT))
                     : '0;

  // sel=0: A is the render target and B is displayed; sel=1 the reverse.
  assign w_addr_a = w_sel ? w_rd_addr : wr_addr_in;
  assign w_addr_b = w_sel ? wr_addr_in : w_rd_addr;

  fb_swap_ctrl u_swap_ctrl (
    .pixel_clk_in    (pixel_clk_in),
    .rst_n_in        (rst_n_in),
    .wr_last_acc_in  (w_wr_last_acc),
    .video_last_in   (video_last_pixel_in),
    .sel_out         (w_sel),
    .wr_ready_out    (wr_ready_out),
    .swap_out        (swap_out),
    .frame_count_out (frame_count_out)
  );

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH       (PIXEL_WIDTH),
    .RAM_DEPTH       (c_depth),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_buf_a (
    .addra  (w_addr_a),
    .dina   (wr_pixel_in),
    .clka   (pixel_clk_in),
    .wea    (w_wr_mem && !w_sel),
    .ena    (1'b1),
    .rsta   (1'b0),
    .regcea (1'b1),
    .douta  (w_dout_a)
  );

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH       (PIXEL_WIDTH),
    .RAM_DEPTH       (c_depth),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_buf_b (
    .addra  (w_addr_b),
    .dina   (wr_pixel_in),
    .clka   (pixel_clk_in),
    .wea    (w_wr_mem && w_sel),
    .ena    (1'b1),
    .rsta   (1'b0),
    .regcea (1'b1),
    .douta  (w_dout_b)
  );

  // Track validity and buffer selection alongside the two-stage RAM read.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid_d1 <= 1'b0;
      r_valid_d2 <= 1'b0;
      r_sel_d1   <= 1'b0;
      r_sel_d2   <= 1'b0;
    end else begin
      r_valid_d1 <= w_in_active;
      r_valid_d2 <= r_valid_d1;
      r_sel_d1   <= w_sel;
      r_sel_d2   <= r_sel_d1;
    end
  end

  assign w_rd_pix = r_sel_d2 ? w_dout_a : w_dout_b;

`ifdef FB_TEST_PATTERN_EN
  logic       r_pattern_on;
  logic       r_pat_d1;
  logic       r_pat_d2;
  logic [2:0] r_bar_d1;
  logic [2:0] r_bar_d2;

  // Colour bars stay up until the first swap delivers a rendered frame.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pattern_on <= 1'b1;
      r_pat_d1     <= 1'b1;
      r_pat_d2     <= 1'b1;
      r_bar_d1     <= 3'd0;
      r_bar_d2     <= 3'd0;
    end else begin
      if (swap_out) r_pattern_on <= 1'b0;
      r_pat_d1 <= r_pattern_on && !swap_out;
      r_pat_d2 <= r_pat_d1;
      r_bar_d1 <= hcount_in[10:8];
      r_bar_d2 <= r_bar_d1;
    end
  end

  // Blank outside the active area, otherwise bars or buffer contents.
  always_comb begin
    rgb_out = 24'd0;
    if (r_valid_d2) rgb_out = r_pat_d2 ? test_bar(r_bar_d2) : rgb565_to_888(rgb565_t'(w_rd_pix));
  end
`else
  // Blank outside the active area, otherwise the expanded display-buffer pixel.
  always_comb begin
    rgb_out = 24'd0;
    if (r_valid_d2) rgb_out = rgb565_to_888(rgb565_t'(w_rd_pix));
  end
`endif

  assign rgb_valid_out = r_valid_d2;

endmodule
`default_nettype wire

// File: tb/tb_swap_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : tb_swap_frame_buffer                                  |
// | Purpose   : Directed self-checking bench for swap_frame_buffer    |
// |             (default build, test pattern disabled).               |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_swap_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        video_last;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [15:0] wr_pixel;
  logic        wr_last;
  logic        wr_ready;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic        swap;
  logic [15:0] frame_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  swap_frame_buffer u_dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .hcount_in           (hcount),
    .vcount_in           (vcount),
    .video_last_pixel_in (video_last),
    .wr_valid_in         (wr_valid),
    .wr_addr_in          (wr_addr),
    .wr_pixel_in         (wr_pixel),
    .wr_last_in          (wr_last),
    .wr_ready_out        (wr_ready),
    .rgb_out             (rgb),
    .rgb_valid_out       (rgb_valid),
    .swap_out            (swap),
    .frame_count_out     (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [15:0] a, input logic [15:0] p, input logic last);
    wr_valid = 1'b1; wr_addr = a; wr_pixel = p; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic vid_pulse();
    video_last = 1'b1;
    tick();
    video_last = 1'b0;
  endtask

  task automatic read_px(input string tag, input logic [10:0] h, input logic [9:0] v,
                         input logic [23:0] exp);
    hcount = h; vcount = v;
    tick();
    tick();
    check({tag, "_valid"}, 32'(rgb_valid), 32'd1);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; hcount = '0; vcount = '0; video_last = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_pixel = '0; wr_last = 1'b0;
    repeat (3) tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_swap", 32'(swap), 32'd0);
    check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    rst_n = 1'b1;
    tick();

    // Red pixel into A, then display end: one swap, A becomes visible.
    write_px(16'd0, 16'hF800, 1'b1);
    check("wrdone_ready", 32'(wr_ready), 32'd0);
    check("wrdone_no_swap", 32'(swap), 32'd0);
    vid_pulse();
    check("swap1_pulse", 32'(swap), 32'd1);
    check("swap1_count", 32'(frame_count), 32'd1);
    check("swap1_ready", 32'(wr_ready), 32'd1);
    tick();
    check("swap1_pulse_end", 32'(swap), 32'd0);
    read_px("red_h0v0", 11'd0, 10'd0, 24'hFF0000);
    read_px("red_h3v3", 11'd3, 10'd3, 24'hFF0000);

    // Fill B, then hammer it with writes while WR_DONE holds ready low.
    write_px(16'd0, 16'h001F, 1'b0);
    write_px(16'd5, 16'h07E0, 1'b1);
    bad = 0;
    wr_valid = 1'b1; wr_addr = 16'd0; wr_pixel = 16'hFFFF; wr_last = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (wr_ready !== 1'b0) bad++;
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    check("ready_low_100", 32'(bad), 32'd0);
    check("no_swap_while_blocked", 32'(frame_count), 32'd1);
    vid_pulse();
    check("swap2_count", 32'(frame_count), 32'd2);
    read_px("blue_unmodified", 11'd0, 10'd0, 24'h0000FF);
    read_px("green_h20", 11'd20, 10'd0, 24'h00FF00);

    // Simultaneous wr_last and video_last: exactly one swap, stays in RUN.
    video_last = 1'b1;
    write_px(16'd1, 16'hFFFF, 1'b1);
    video_last = 1'b0;
    check("both_swap_pulse", 32'(swap), 32'd1);
    check("both_count", 32'(frame_count), 32'd3);
    check("both_ready", 32'(wr_ready), 32'd1);
    read_px("white_h4", 11'd4, 10'd0, 24'hFFFFFF);
    read_px("red_kept", 11'd0, 10'd0, 24'hFF0000);

    // VID_DONE ignores repeated video_last, then wr_last swaps.
    vid_pulse();
    vid_pulse();
    check("vid_repeat_count", 32'(frame_count), 32'd3);
    check("vid_repeat_swap", 32'(swap), 32'd0);
    write_px(16'd2, 16'h8410, 1'b1);
    check("viddone_swap_pulse", 32'(swap), 32'd1);
    check("viddone_count", 32'(frame_count), 32'd4);
    read_px("gray_h8", 11'd8, 10'd0, 24'h848284);
    read_px("blue_kept", 11'd0, 10'd0, 24'h0000FF);

    // Out-of-range write with wr_last still completes the render frame.
    write_px(16'd57600, 16'h1234, 1'b1);
    check("oor_wrdone_ready", 32'(wr_ready), 32'd0);
    vid_pulse();
    check("oor_swap_count", 32'(frame_count), 32'd5);
    read_px("oor_red_kept", 11'd0, 10'd0, 24'hFF0000);
    read_px("oor_white_kept", 11'd4, 10'd0, 24'hFFFFFF);

    // Asynchronous reset while in WR_DONE.
    write_px(16'd3, 16'h001F, 1'b1);
    check("pre_rst_ready", 32'(wr_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(wr_ready), 32'd1);
    check("async_rst_count", 32'(frame_count), 32'd0);
    check("async_rst_valid", 32'(rgb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read_px("rst_b_retained", 11'd12, 10'd0, 24'h0000FF);
    vid_pulse();
    check("rst_flag_dropped", 32'(frame_count), 32'd0);
    write_px(16'd10, 16'h07E0, 1'b1);
    check("rst_next_swap", 32'(frame_count), 32'd1);
    read_px("rst_a_retained", 11'd0, 10'd0, 24'hFF0000);
    read_px("green_h40", 11'd40, 10'd0, 24'h00FF00);

    // Active-area boundaries and exact 2-cycle latency.
    hcount = 11'd1280; vcount = 10'd0;
    tick(); tick();
    check("h1280_valid", 32'(rgb_valid), 32'd0);
    check("h1280_rgb", 32'(rgb), 32'd0);
    hcount = 11'd0; vcount = 10'd720;
    tick(); tick();
    check("v720_valid", 32'(rgb_valid), 32'd0);
    hcount = 11'd0; vcount = 10'd0;
    tick();
    check("latency_1cyc_valid", 32'(rgb_valid), 32'd0);
    tick();
    check("latency_2cyc_valid", 32'(rgb_valid), 32'd1);
    check("latency_2cyc_rgb", 32'(rgb), 32'hFF0000);
    hcount = 11'd1279; vcount = 10'd719;
    tick(); tick();
    check("corner_valid", 32'(rgb_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
